// File: rtl/fp_adder_pkg.sv
// Shared sizing for the floating-point adder datapath (mantissa, exponent and
// normalisation blocks).
package fp_adder_pkg;

    localparam int unsigned MANT_WIDTH_DEFAULT = 24;

    // Width needed to hold a leading-zero count of 0..width inclusive.
    function automatic int unsigned lz_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fp_leading_zero_counter.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_leading_zero_counter
    import fp_adder_pkg::*;
#(
    parameter  int unsigned WIDTH = MANT_WIDTH_DEFAULT,
    localparam int unsigned CW    = lz_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o
);

    // Scan upward so the most significant set bit is the last one to win.
    always_comb begin
        count_o = CW'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                count_o = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_mantissa_addsub_pipe.sv
// Two-stage sign-magnitude mantissa add/subtract with valid/ready handshakes:
// stage 1 holds the raw sum and sign, stage 2 the flags and leading-zero count.
module fp_mantissa_addsub_pipe
    import fp_adder_pkg::*;
#(
    parameter  int unsigned MANT_WIDTH = MANT_WIDTH_DEFAULT,
    localparam int unsigned LZ_WIDTH   = lz_width(MANT_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_WIDTH-1:0] input1_magnitude,
    input  logic [MANT_WIDTH-1:0] input2_magnitude,
    input  logic                  input1_sign,
    input  logic                  input2_sign,
    input  logic                  op_subtract,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MANT_WIDTH-1:0] result_magnitude,
    output logic                  carry_out,
    output logic                  result_sign,
    output logic                  result_zero,
    output logic [LZ_WIDTH-1:0]   leading_zeros
);

    localparam int unsigned SUM_W = MANT_WIDTH + 1;

    logic                  eff_sign2_c;
    logic                  eff_sub_c;
    logic [SUM_W-1:0]      sum_c;
    logic                  sign_c;
    logic                  s2_adv_c;
    logic                  accept_c;
    logic [LZ_WIDTH-1:0]   lz_c;

    logic                  s1_valid_q, s1_valid_d;
    logic [SUM_W-1:0]      s1_sum_q,   s1_sum_d;
    logic                  s1_sign_q,  s1_sign_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [MANT_WIDTH-1:0] s2_mag_q,   s2_mag_d;
    logic                  s2_carry_q, s2_carry_d;
    logic                  s2_sign_q,  s2_sign_d;
    logic                  s2_zero_q,  s2_zero_d;
    logic [LZ_WIDTH-1:0]   s2_lz_q,    s2_lz_d;

    // Sign-magnitude add/subtract; equal-magnitude subtraction is forced to +0.
    always_comb begin
        eff_sign2_c = input2_sign ^ op_subtract;
        eff_sub_c   = input1_sign ^ eff_sign2_c;
        sum_c       = '0;
        sign_c      = 1'b0;
        if (!eff_sub_c) begin
            sum_c  = SUM_W'(input1_magnitude) + SUM_W'(input2_magnitude);
            sign_c = input1_sign;
        end else if (input1_magnitude > input2_magnitude) begin
            sum_c  = SUM_W'(input1_magnitude - input2_magnitude);
            sign_c = input1_sign;
        end else if (input1_magnitude < input2_magnitude) begin
            sum_c  = SUM_W'(input2_magnitude - input1_magnitude);
            sign_c = eff_sign2_c;
        end
    end

    fp_leading_zero_counter #(
        .WIDTH (MANT_WIDTH)
    ) u_lzc (
        .data_i  (s1_sum_q[MANT_WIDTH-1:0]),
        .count_o (lz_c)
    );

    // A stage advances when the stage after it is empty or being consumed.
    assign s2_adv_c = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv_c;
    assign accept_c = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_sign_d  = s1_sign_q;
        s2_valid_d = s2_valid_q;
        s2_mag_d   = s2_mag_q;
        s2_carry_d = s2_carry_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_lz_d    = s2_lz_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (accept_c) begin
            s1_sum_d  = sum_c;
            s1_sign_d = sign_c;
        end

        if (s2_adv_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mag_d   = s1_sum_q[MANT_WIDTH-1:0];
                s2_carry_d = s1_sum_q[MANT_WIDTH];
                s2_sign_d  = s1_sign_q;
                s2_zero_d  = (s1_sum_q == '0);
                s2_lz_d    = s1_sum_q[MANT_WIDTH] ? '0 : lz_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_sign_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_mag_q   <= '0;
            s2_carry_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_lz_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_sign_q  <= s1_sign_d;
            s2_valid_q <= s2_valid_d;
            s2_mag_q   <= s2_mag_d;
            s2_carry_q <= s2_carry_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_lz_q    <= s2_lz_d;
        end
    end

    assign out_valid        = s2_valid_q;
    assign result_magnitude = s2_mag_q;
    assign carry_out        = s2_carry_q;
    assign result_sign      = s2_sign_q;
    assign result_zero      = s2_zero_q;
    assign leading_zeros    = s2_lz_q;

endmodule

// File: tb/tb_fp_mantissa_addsub_pipe.sv
// Directed bench for fp_mantissa_addsub_pipe at MANT_WIDTH = 24.
module tb_fp_mantissa_addsub_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] input1_magnitude;
    logic [23:0] input2_magnitude;
    logic        input1_sign;
    logic        input2_sign;
    logic        op_subtract;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] result_magnitude;
    logic        carry_out;
    logic        result_sign;
    logic        result_zero;
    logic [4:0]  leading_zeros;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [23:0] a;
        logic        as;
        logic [23:0] b;
        logic        bs;
        logic        sub;
        logic [23:0] mag;
        logic        c;
        logic        s;
        logic        z;
        logic [4:0]  lz;
    } vec_t;

    fp_mantissa_addsub_pipe #(.MANT_WIDTH(24)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .input1_magnitude (input1_magnitude),
        .input2_magnitude (input2_magnitude),
        .input1_sign      (input1_sign),
        .input2_sign      (input2_sign),
        .op_subtract      (op_subtract),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result_magnitude (result_magnitude),
        .carry_out        (carry_out),
        .result_sign      (result_sign),
        .result_zero      (result_zero),
        .leading_zeros    (leading_zeros)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_add(input logic [23:0] a, input logic as,
                             input logic [23:0] b, input logic bs, input logic sub);
        input1_magnitude = a;
        input1_sign      = as;
        input2_magnitude = b;
        input2_sign      = bs;
        op_subtract      = sub;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive_add(24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({out_valid, result_magnitude, carry_out, result_sign, result_zero, leading_zeros} !== 33'h0) begin
            tests_failed++;
            $display("FAIL reset_hold: got valid=%b mag=%h c=%b s=%b z=%b lz=%0d, want all 0",
                     out_valid, result_magnitude, carry_out, result_sign, result_zero, leading_zeros);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors;
        vec_t v [9];
        v[0] = '{24'h800000, 1'b0, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 5'd0};
        v[1] = '{24'h400000, 1'b1, 24'h200000, 1'b1, 1'b0, 24'h600000, 1'b0, 1'b1, 1'b0, 5'd1};
        v[2] = '{24'h123456, 1'b0, 24'h123456, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b1, 5'd24};
        v[3] = '{24'h000010, 1'b0, 24'h000100, 1'b1, 1'b0, 24'h0000F0, 1'b0, 1'b1, 1'b0, 5'd16};
        v[4] = '{24'h000000, 1'b1, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 5'd24};
        v[5] = '{24'h000001, 1'b0, 24'h000003, 1'b0, 1'b1, 24'h000002, 1'b0, 1'b1, 1'b0, 5'd22};
        v[6] = '{24'hFFFFFF, 1'b0, 24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFE, 1'b1, 1'b0, 1'b0, 5'd0};
        v[7] = '{24'h800000, 1'b1, 24'h000001, 1'b0, 1'b1, 24'h800001, 1'b0, 1'b1, 1'b0, 5'd0};
        v[8] = '{24'h000100, 1'b0, 24'h000010, 1'b1, 1'b0, 24'h0000F0, 1'b0, 1'b0, 1'b0, 5'd16};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_add(v[i].a, v[i].as, v[i].b, v[i].bs, v[i].sub);
            in_valid = 1'b1;
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL vec%0d_in_ready: got %b, want 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            drive_add(24'hABCDEF, 1'b1, 24'h111111, 1'b0, 1'b1);
            #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL vec%0d_latency1: got out_valid=%b, want 0", i, out_valid);
            end
            @(negedge clk);
            #1;
            tests_run++;
            if ({out_valid, result_magnitude, carry_out, result_sign, result_zero, leading_zeros} !==
                {1'b1, v[i].mag, v[i].c, v[i].s, v[i].z, v[i].lz}) begin
                tests_failed++;
                $display("FAIL vec%0d_result: got valid=%b mag=%h c=%b s=%b z=%b lz=%0d, want valid=1 mag=%h c=%b s=%b z=%b lz=%0d",
                         i, out_valid, result_magnitude, carry_out, result_sign, result_zero, leading_zeros,
                         v[i].mag, v[i].c, v[i].s, v[i].z, v[i].lz);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stream;
        logic [23:0] a [3];
        logic [23:0] emag [3];
        logic [4:0]  elz [3];
        a[0] = 24'h800000; emag[0] = 24'h800000; elz[0] = 5'd0;
        a[1] = 24'h000001; emag[1] = 24'h000001; elz[1] = 5'd23;
        a[2] = 24'h400000; emag[2] = 24'h400000; elz[2] = 5'd1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = (c < 3);
            if (c < 3) drive_add(a[c], 1'b0, 24'h0, 1'b0, 1'b0);
            #1;
            tests_run++;
            if (c >= 2) begin
                if ({out_valid, result_magnitude, leading_zeros} !== {1'b1, emag[c-2], elz[c-2]}) begin
                    tests_failed++;
                    $display("FAIL stream_out%0d: got valid=%b mag=%h lz=%0d, want valid=1 mag=%h lz=%0d",
                             c - 2, out_valid, result_magnitude, leading_zeros, emag[c-2], elz[c-2]);
                end
            end else if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stream_fill%0d: got in_ready=%b out_valid=%b, want 1 0", c, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [23:0] a [4];
        logic [23:0] emag [4];
        logic [4:0]  elz [4];
        int sent;
        int got;
        int last_c;
        a[0] = 24'h000100; emag[0] = 24'h000101; elz[0] = 5'd15;
        a[1] = 24'h000200; emag[1] = 24'h000201; elz[1] = 5'd14;
        a[2] = 24'h000300; emag[2] = 24'h000301; elz[2] = 5'd14;
        a[3] = 24'h000400; emag[3] = 24'h000401; elz[3] = 5'd13;
        sent   = 0;
        got    = 0;
        last_c = -1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            if (sent < 4) drive_add(a[sent], 1'b0, 24'h000001, 1'b0, 1'b0);
            #1;
            if (c == 2) begin
                tests_run++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    tests_failed++;
                    $display("FAIL b2b_stall: got in_ready=%b accepted=%0d, want 0 2", in_ready, sent);
                end
            end
            if (c >= 2 && c < 5) begin
                tests_run++;
                if ({out_valid, result_magnitude, leading_zeros} !== {1'b1, emag[0], elz[0]}) begin
                    tests_failed++;
                    $display("FAIL b2b_hold_c%0d: got valid=%b mag=%h lz=%0d, want valid=1 mag=%h lz=%0d",
                             c, out_valid, result_magnitude, leading_zeros, emag[0], elz[0]);
                end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if ({result_magnitude, result_sign, leading_zeros} !== {emag[got], 1'b0, elz[got]}) begin
                    tests_failed++;
                    $display("FAIL b2b_out%0d: got mag=%h s=%b lz=%0d, want mag=%h s=0 lz=%0d",
                             got, result_magnitude, result_sign, leading_zeros, emag[got], elz[got]);
                end
                got++;
                last_c = c;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (got != 4 || last_c != 8) begin
            tests_failed++;
            $display("FAIL b2b_drain: got %0d outputs ending cycle %0d, want 4 ending cycle 8", got, last_c);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_in_flight;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive_add(24'h000500 + 24'(c), 1'b0, 24'h000001, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rif_pre: got out_valid=%b, want 1", out_valid);
        end
        #1;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, result_magnitude, carry_out, result_sign, result_zero, leading_zeros} !== 33'h0) begin
            tests_failed++;
            $display("FAIL rif_async: got valid=%b mag=%h lz=%0d, want valid=0 mag=0 lz=0",
                     out_valid, result_magnitude, leading_zeros);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL rif_stale%0d: got out_valid=%b in_ready=%b, want 0 1", c, out_valid, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        drive_add(24'h000003, 1'b0, 24'h000004, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({out_valid, result_magnitude, result_sign, result_zero, leading_zeros} !==
            {1'b1, 24'h000007, 1'b0, 1'b0, 5'd21}) begin
            tests_failed++;
            $display("FAIL rif_next: got valid=%b mag=%h s=%b z=%b lz=%0d, want valid=1 mag=000007 s=0 z=0 lz=21",
                     out_valid, result_magnitude, result_sign, result_zero, leading_zeros);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rif_single: got out_valid=%b, want 0", out_valid);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_vectors();
        test_stream();
        test_back_to_back();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fp_mantissa_addsub_pipe.md
FP_MANTISSA_ADDSUB_PIPE -- requirements
Module: fp_mantissa_addsub_pipe

Interface
REQ-001 SHALL have parameter: MANT_WIDTH, 24, mantissa magnitude width incl. hidden bit (legal 4..64).
REQ-002 SHALL have localparam: LZ_WIDTH, $clog2(MANT_WIDTH+1), width of leading-zero count.
REQ-003 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: in_valid in 1 / in_ready out 1, input handshake.
REQ-006 SHALL have ports: input1_magnitude, input2_magnitude  in  MANT_WIDTH  unsigned mantissas.
REQ-007 SHALL have ports: input1_sign, input2_sign  in  1  operand signs (1 = negative).
REQ-008 SHALL have port: op_subtract  in  1  1 = compute input1 - input2, 0 = input1 + input2.
REQ-009 SHALL have ports: out_valid out 1 / out_ready in 1, output handshake.
REQ-010 SHALL have ports: result_magnitude out MANT_WIDTH; carry_out out 1 (bit MANT_WIDTH of the sum).
REQ-011 SHALL have ports: result_sign out 1; result_zero out 1; leading_zeros out LZ_WIDTH.

Function
REQ-012 SHALL form effective sign2 = input2_sign XOR op_subtract; effective subtraction = input1_sign XOR effective sign2.
REQ-013 Effective add: magnitude = input1 + input2 at MANT_WIDTH+1 bits, sign = input1_sign (-a + -b is negative; -0 + -0 = -0).
REQ-014 Effective subtract: magnitude = larger minus smaller, carry_out = 0, sign = sign of larger operand; equal magnitudes give zero with sign 0.
REQ-015 result_zero SHALL be 1 iff {carry_out, result_magnitude} == 0.
REQ-016 leading_zeros SHALL be 0 if carry_out = 1, MANT_WIDTH if result_zero, else count of leading 0s in result_magnitude.
REQ-017 Two register stages: S1 registers add/sub result and sign; S2 registers leading-zero count and outputs.
REQ-018 Latency SHALL be exactly 2 cycles from accepted input (in_valid && in_ready) to out_valid with no backpressure; throughput 1 per cycle.
REQ-019 in_ready SHALL be combinational: 1 when S1 is empty or S1 advances this cycle; stage N advances when stage N+1 is empty or is consumed.
REQ-020 While out_valid && !out_ready all outputs SHALL hold stable; no transaction dropped, duplicated or reordered.
REQ-021 Simultaneous output consume and input accept in a full pipeline SHALL sustain full throughput without a bubble.
REQ-022 Inputs SHALL be ignored when in_valid = 0 or in_ready = 0.

Reset
REQ-023 reset_n low SHALL asynchronously clear both stage-valid flags and all data registers; out_valid = 0, all result outputs = 0.
REQ-024 After reset_n rises, in_ready SHALL be 1 in the first cycle; in-flight transactions at reset are discarded, none reappear.

Structure
REQ-025 Package fp_adder_pkg SHALL hold default MANT_WIDTH and a function for LZ_WIDTH, shared with the exponent and normalisation blocks.
REQ-026 Sub-module fp_leading_zero_counter (parameter WIDTH, combinational) SHALL compute the S2 count; all else stays in this module.

Verification (MANT_WIDTH = 24, out_ready = 1 unless stated)
REQ-027 +0x800000 + +0x800000, op_subtract 0 -> after 2 cycles carry_out 1, magnitude 0x000000, sign 0, zero 0, lz 0.
REQ-028 -0x400000 + -0x200000 -> magnitude 0x600000, sign 1, carry 0, lz 1.
REQ-029 +0x123456 with op_subtract 1, input2 +0x123456 -> magnitude 0, sign 0, zero 1, lz 24.
REQ-030 +0x000010 + -0x000100 -> magnitude 0x0000F0, sign 1, lz 16.
REQ-031 Stream 4 inputs back-to-back with out_ready low 5 cycles -> in_ready drops after 2 accepted; outputs held stable; all 4 emerge in order after release.
REQ-032 Assert reset_n low with 2 transactions in flight -> out_valid 0 immediately (asynchronous); after release no stale output, next input returns in 2 cycles.
